// File: rtl/riscv_tb_pkg.sv
// ---------------------------------------------------------------------------
// riscv_tb_pkg
// Shared types and helpers for the RISC-V run monitor.
//   state_t       : run monitor FSM encoding (HOLD, RUN, CHECK, DONE).
//   XLEN_DEFAULT  : default datapath width of the watched core.
//   flat_slice()  : pulls slice i (width w) out of a flat packed vector.
// ---------------------------------------------------------------------------
package riscv_tb_pkg;

    localparam int XLEN_DEFAULT = 64;

    // Upper bounds for flat_slice(). A flat vector of up to FLAT_MAX bits
    // holding slices of up to SLICE_MAX bits each is supported.
    localparam int SLICE_MAX = 128;
    localparam int FLAT_MAX  = 4096;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // With constant i and w this reduces to plain wiring.
    function automatic logic [SLICE_MAX-1:0] flat_slice(
        input logic [FLAT_MAX-1:0] flat,
        input int unsigned         i,
        input int unsigned         w
    );
        logic [FLAT_MAX-1:0]  shifted;
        logic [SLICE_MAX-1:0] keep;
        shifted = flat >> (i * w);
        // For w == SLICE_MAX the shift wraps to 0 and the subtract gives all ones.
        keep    = (SLICE_MAX'(1) << w) - SLICE_MAX'(1);
        return shifted[SLICE_MAX-1:0] & keep;
    endfunction

endpackage

// File: rtl/riscv_run_monitor_if.sv
// ---------------------------------------------------------------------------
// riscv_run_monitor_if
// Bundles the signals between a RISC-V core (plus its expected-value source)
// and the run monitor.
//   master : drives pc_out, val_flat, exp_flat, chk_mask; observes status.
//   slave  : the monitor; drives core_reset, done, pass, fail, timeout,
//            cycle_count, mismatch_idx and dbg_state.
// Handshake: there is no valid/ready pair here. Inputs are sampled every
// rising edge; status outputs are level signals that are sticky once done=1.
// ---------------------------------------------------------------------------
interface riscv_run_monitor_if #(
    parameter int XLEN   = 64,
    parameter int N_VALS = 4,
    parameter int CNT_W  = 32,
    parameter int IDX_W  = 2
);
    import riscv_tb_pkg::*;

    logic [XLEN-1:0]        pc_out;
    logic [N_VALS*XLEN-1:0] val_flat;
    logic [N_VALS*XLEN-1:0] exp_flat;
    logic [N_VALS-1:0]      chk_mask;

    logic                   core_reset;
    logic                   done;
    logic                   pass;
    logic                   fail;
    logic                   timeout;
    logic [CNT_W-1:0]       cycle_count;
    logic [IDX_W-1:0]       mismatch_idx;
    state_t                 dbg_state;

    modport master (
        output pc_out, val_flat, exp_flat, chk_mask,
        input  core_reset, done, pass, fail, timeout, cycle_count,
               mismatch_idx, dbg_state
    );

    modport slave (
        input  pc_out, val_flat, exp_flat, chk_mask,
        output core_reset, done, pass, fail, timeout, cycle_count,
               mismatch_idx, dbg_state
    );

endinterface

// File: rtl/riscv_halt_detector.sv
// ---------------------------------------------------------------------------
// riscv_halt_detector
// Declares a halt once the PC has stayed unchanged for HALT_STABLE
// consecutive samples while enabled.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   enable     : 1 while the core runs; 0 clears stable_cnt and loads last_pc
//   pc_out     : current core PC
//   halted     : combinational, high in the cycle the halt condition is met
// ---------------------------------------------------------------------------
module riscv_halt_detector #(
    parameter int XLEN        = 64,
    parameter int HALT_STABLE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [XLEN-1:0] pc_out,
    output logic            halted
);

    // One extra bit so the counter can hold HALT_STABLE itself.
    localparam int STB_W = $clog2(HALT_STABLE) + 1;
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(HALT_STABLE - 1);

    logic [XLEN-1:0]  last_pc_q,    last_pc_d;
    logic [STB_W-1:0] stable_cnt_q, stable_cnt_d;
    logic             pc_same;

    always_comb begin
        pc_same      = (pc_out == last_pc_q);
        last_pc_d    = pc_out;
        stable_cnt_d = '0;
        halted       = 1'b0;
        if (enable) begin
            if (pc_same) begin
                stable_cnt_d = stable_cnt_q + 1'b1;
            end
            halted = pc_same && (stable_cnt_q == STB_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_pc_q    <= '0;
            stable_cnt_q <= '0;
        end else begin
            last_pc_q    <= last_pc_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

endmodule

// File: rtl/riscv_run_monitor.sv
// ---------------------------------------------------------------------------
// riscv_run_monitor
// Run controller and result checker for a RISC-V core: holds the core in
// reset for RESET_CYCLES cycles, lets it run until the PC self-loops (halt)
// or MAX_CYCLES elapse (timeout), then compares N_VALS watched values with
// their expected values one per cycle and reports pass or fail.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : riscv_run_monitor_if.slave
//                in : pc_out, val_flat, exp_flat, chk_mask
//                out: core_reset, done, pass, fail, timeout, cycle_count,
//                     mismatch_idx, dbg_state (current FSM state)
// ---------------------------------------------------------------------------
module riscv_run_monitor
    import riscv_tb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int N_VALS       = 4,
    parameter int RESET_CYCLES = 3,
    parameter int HALT_STABLE  = 4,
    parameter int MAX_CYCLES   = 1024,
    parameter int CNT_W        = 32,
    parameter int IDX_W        = 2
) (
    input logic               clk,
    input logic               reset,
    riscv_run_monitor_if.slave bus
);

    localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_VALS - 1);

    state_t            state_q,        state_d;
    logic [HOLD_W-1:0] hold_cnt_q,     hold_cnt_d;
    logic [CNT_W-1:0]  cycle_count_q,  cycle_count_d;
    logic [IDX_W-1:0]  chk_idx_q,      chk_idx_d;
    logic [IDX_W-1:0]  mismatch_idx_q, mismatch_idx_d;
    logic              done_q,         done_d;
    logic              pass_q,         pass_d;
    logic              fail_q,         fail_d;
    logic              timeout_q,      timeout_d;

    logic              core_reset;
    logic              run_en;
    logic              halted;
    logic [N_VALS-1:0] slot_ok;

    riscv_halt_detector #(
        .XLEN        (XLEN),
        .HALT_STABLE (HALT_STABLE)
    ) u_halt (
        .clk    (clk),
        .reset  (reset),
        .enable (run_en),
        .pc_out (bus.pc_out),
        .halted (halted)
    );

    // Every slot is compared in parallel; CHECK just walks the result vector
    // so the first mismatch is reported in index order. A masked slot always
    // counts as a match.
    for (genvar gi = 0; gi < N_VALS; gi++) begin : g_cmp
        logic [XLEN-1:0] val_i;
        logic [XLEN-1:0] exp_i;
        assign val_i       = XLEN'(flat_slice(FLAT_MAX'(bus.val_flat), gi, XLEN));
        assign exp_i       = XLEN'(flat_slice(FLAT_MAX'(bus.exp_flat), gi, XLEN));
        assign slot_ok[gi] = !bus.chk_mask[gi] || (val_i == exp_i);
    end

    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        cycle_count_d  = cycle_count_q;
        chk_idx_d      = chk_idx_q;
        mismatch_idx_d = mismatch_idx_q;
        done_d         = done_q;
        pass_d         = pass_q;
        fail_d         = fail_q;
        timeout_d      = timeout_q;
        core_reset     = 1'b0;
        run_en         = 1'b0;

        case (state_q)
            HOLD: begin
                core_reset = 1'b1;
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                run_en = 1'b1;
                // Halt is tested first so it wins over a simultaneous timeout.
                // cycle_count only advances while the run continues, so it
                // ends at the index of the last RUN cycle.
                if (halted) begin
                    state_d   = CHECK;
                    chk_idx_d = '0;
                end else if (cycle_count_q == CNT_LAST) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    cycle_count_d = cycle_count_q + 1'b1;
                end
            end
            CHECK: begin
                if (!slot_ok[chk_idx_q]) begin
                    mismatch_idx_d = chk_idx_q;
                    fail_d         = 1'b1;
                    done_d         = 1'b1;
                    state_d        = DONE;
                end else if (chk_idx_q == IDX_LAST) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    chk_idx_d = chk_idx_q + 1'b1;
                end
            end
            DONE: begin
                // Everything holds until reset.
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HOLD;
            hold_cnt_q     <= '0;
            cycle_count_q  <= '0;
            chk_idx_q      <= '0;
            mismatch_idx_q <= '0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            fail_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            cycle_count_q  <= cycle_count_d;
            chk_idx_q      <= chk_idx_d;
            mismatch_idx_q <= mismatch_idx_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            fail_q         <= fail_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.core_reset   = core_reset;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.timeout      = timeout_q;
    assign bus.cycle_count  = cycle_count_q;
    assign bus.mismatch_idx = mismatch_idx_q;
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_riscv_run_monitor
// Drives PC traces and watched values into riscv_run_monitor and checks its
// status outputs against a reference model that works from the halt and
// check rules directly: a halt is the first run cycle that closes a run of
// HALT_STABLE unchanged PC samples, and the result is the first masked slot
// whose value differs from its expected value.
// ---------------------------------------------------------------------------
module tb_riscv_run_monitor;
    import riscv_tb_pkg::*;

    localparam int XLEN         = 64;
    localparam int N_VALS       = 4;
    localparam int RESET_CYCLES = 3;
    localparam int HALT_STABLE  = 4;
    localparam int MAX_CYCLES   = 16;
    localparam int CNT_W        = 32;
    localparam int IDX_W        = 2;
    localparam int TRACE_MAX    = 64;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    riscv_run_monitor_if #(
        .XLEN(XLEN), .N_VALS(N_VALS), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) bus ();

    riscv_run_monitor #(
        .XLEN(XLEN), .N_VALS(N_VALS), .RESET_CYCLES(RESET_CYCLES),
        .HALT_STABLE(HALT_STABLE), .MAX_CYCLES(MAX_CYCLES),
        .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scenario description ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0]   pc_hold;
    logic [XLEN-1:0]   pc_trace [TRACE_MAX];
    int                trace_len;
    logic [XLEN-1:0]   val_a [N_VALS];
    logic [XLEN-1:0]   exp_a [N_VALS];
    logic [N_VALS-1:0] mask;

    // Scoreboard: per scenario the model pushes flags {done,pass,fail,timeout},
    // cycle_count, mismatch_idx and the run-relative cycle where done rises.
    logic [CNT_W-1:0] exp_q [$];

    // PC presented in run cycle k (the last trace entry is held forever).
    function automatic logic [XLEN-1:0] pc_at(input int k);
        if (k < trace_len) return pc_trace[k];
        return pc_trace[trace_len-1];
    endfunction

    function automatic void model();
        int              same_run;
        int              halt_k;
        int              first_bad;
        logic [XLEN-1:0] prev;
        logic [XLEN-1:0] cur;
        same_run = 0;
        halt_k   = -1;
        prev     = pc_hold;
        for (int k = 0; k < MAX_CYCLES; k++) begin
            cur      = pc_at(k);
            same_run = (cur == prev) ? same_run + 1 : 0;
            prev     = cur;
            if (same_run >= HALT_STABLE) begin
                halt_k = k;
                break;
            end
        end
        first_bad = -1;
        for (int i = N_VALS - 1; i >= 0; i--) begin
            if (mask[i] && (val_a[i] != exp_a[i])) first_bad = i;
        end
        if (halt_k < 0) begin
            exp_q.push_back(CNT_W'(4'b1011));
            exp_q.push_back(CNT_W'(MAX_CYCLES - 1));
            exp_q.push_back(CNT_W'(0));
            exp_q.push_back(CNT_W'(MAX_CYCLES));
        end else if (first_bad >= 0) begin
            exp_q.push_back(CNT_W'(4'b1010));
            exp_q.push_back(CNT_W'(halt_k));
            exp_q.push_back(CNT_W'(first_bad));
            exp_q.push_back(CNT_W'(halt_k + first_bad + 2));
        end else begin
            exp_q.push_back(CNT_W'(4'b1100));
            exp_q.push_back(CNT_W'(halt_k));
            exp_q.push_back(CNT_W'(0));
            exp_q.push_back(CNT_W'(halt_k + N_VALS + 1));
        end
    endfunction

    function automatic void set_default_vals();
        for (int i = 0; i < N_VALS; i++) begin
            val_a[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 17 + 3);
            exp_a[i] = val_a[i];
        end
        mask = '1;
    endfunction

    // ---------------- driver ----------------
    // abort_at >= 0 asserts reset in that run-relative cycle instead of
    // waiting for done, and checks the restored reset values.
    task automatic run_scenario(input string name, input int abort_at);
        int               t, hold_seen, done_t, c;
        bit               cr_fell, aborted;
        logic [CNT_W-1:0] e_flags, e_count, e_midx, e_done_t, o_flags;
        logic [CNT_W-1:0] held_count;

        for (int i = 0; i < N_VALS; i++) begin
            bus.val_flat[i*XLEN +: XLEN] = val_a[i];
            bus.exp_flat[i*XLEN +: XLEN] = exp_a[i];
        end
        bus.chk_mask = mask;
        bus.pc_out   = pc_hold;
        model();
        e_flags  = exp_q.pop_front();
        e_count  = exp_q.pop_front();
        e_midx   = exp_q.pop_front();
        e_done_t = exp_q.pop_front();

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        t = 0; hold_seen = 0; done_t = -1; c = 0;
        cr_fell = 1'b0; aborted = 1'b0;
        while (done_t < 0 && !aborted && c < RESET_CYCLES + MAX_CYCLES + N_VALS + 8) begin
            @(negedge clk);
            c++;
            n_tests++;
            if (bus.pass === 1'b1 && bus.fail === 1'b1) begin
                n_fail++;
                $display("FAIL %s pass_and_fail: got pass=1 fail=1 exp not both", name);
            end
            if (bus.core_reset === 1'b1) begin
                n_tests++;
                if (cr_fell) begin
                    n_fail++;
                    $display("FAIL %s core_reset_rerise: got 1 exp 0 at run cycle %0d", name, t);
                end
                hold_seen++;
                bus.pc_out = pc_hold;
            end else begin
                if (!cr_fell) begin
                    cr_fell = 1'b1;
                    n_tests++;
                    if (hold_seen != RESET_CYCLES) begin
                        n_fail++;
                        $display("FAIL %s core_reset_width: got %0d exp %0d", name, hold_seen, RESET_CYCLES);
                    end
                end
                if (bus.done === 1'b1) begin
                    done_t = t;
                end else if (t == abort_at) begin
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    o_flags = CNT_W'({bus.done, bus.pass, bus.fail, bus.timeout});
                    n_tests++;
                    if (bus.core_reset !== 1'b1 || o_flags !== '0 ||
                        bus.cycle_count !== '0 || bus.mismatch_idx !== '0) begin
                        n_fail++;
                        $display("FAIL %s abort_reset: got core_reset=%b flags=%b count=%0d midx=%0d exp 1 0000 0 0",
                                 name, bus.core_reset, o_flags[3:0], bus.cycle_count, bus.mismatch_idx);
                    end
                    reset   = 1'b0;
                    aborted = 1'b1;
                end else begin
                    bus.pc_out = pc_at(t);
                end
                t++;
            end
        end
        if (aborted) return;

        n_tests++;
        if (done_t < 0) begin
            n_fail++;
            $display("FAIL %s done_timeout: got no done in %0d cycles exp done at run cycle %0d", name, c, e_done_t);
            return;
        end
        n_tests++;
        if (done_t != int'(e_done_t)) begin
            n_fail++;
            $display("FAIL %s done_latency: got run cycle %0d exp %0d", name, done_t, e_done_t);
        end
        o_flags = CNT_W'({bus.done, bus.pass, bus.fail, bus.timeout});
        n_tests++;
        if (o_flags !== e_flags) begin
            n_fail++;
            $display("FAIL %s flags(done,pass,fail,timeout): got %b exp %b", name, o_flags[3:0], e_flags[3:0]);
        end
        n_tests++;
        if (bus.cycle_count !== e_count) begin
            n_fail++;
            $display("FAIL %s cycle_count: got %0d exp %0d", name, bus.cycle_count, e_count);
        end
        n_tests++;
        if (CNT_W'(bus.mismatch_idx) !== e_midx) begin
            n_fail++;
            $display("FAIL %s mismatch_idx: got %0d exp %0d", name, bus.mismatch_idx, e_midx);
        end
        held_count = bus.cycle_count;
        repeat (3) @(negedge clk);
        n_tests++;
        if (CNT_W'({bus.done, bus.pass, bus.fail, bus.timeout}) !== o_flags ||
            bus.cycle_count !== held_count || bus.core_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_hold: got flags=%b count=%0d core_reset=%b exp %b %0d 0",
                     name, {bus.done, bus.pass, bus.fail, bus.timeout}, bus.cycle_count,
                     bus.core_reset, o_flags[3:0], held_count);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.pc_out   = '0;
        bus.val_flat = '0;
        bus.exp_flat = '0;
        bus.chk_mask = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.core_reset !== 1'b1 || bus.done !== 1'b0 || bus.pass !== 1'b0 ||
            bus.fail !== 1'b0 || bus.timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: got core_reset=%b done=%b pass=%b fail=%b timeout=%b exp 1 0 0 0 0",
                     bus.core_reset, bus.done, bus.pass, bus.fail, bus.timeout);
        end
        n_tests++;
        if (bus.cycle_count !== '0 || bus.mismatch_idx !== '0 || bus.dbg_state !== HOLD) begin
            n_fail++;
            $display("FAIL reset counters: got count=%0d midx=%0d state=%0d exp 0 0 0",
                     bus.cycle_count, bus.mismatch_idx, bus.dbg_state);
        end
    endtask

    task automatic setup_basic_trace();
        pc_hold     = '0;
        trace_len   = 4;
        pc_trace[0] = 64'd0;
        pc_trace[1] = 64'd4;
        pc_trace[2] = 64'd8;
        pc_trace[3] = 64'd12;
    endtask

    task automatic test_pass();
        setup_basic_trace();
        set_default_vals();
        run_scenario("pass", -1);
        n_tests++;
        if (bus.cycle_count !== 32'd7 || bus.pass !== 1'b1 || bus.fail !== 1'b0) begin
            n_fail++;
            $display("FAIL pass literal: got count=%0d pass=%b fail=%b exp 7 1 0",
                     bus.cycle_count, bus.pass, bus.fail);
        end
    endtask

    task automatic test_mismatch();
        setup_basic_trace();
        set_default_vals();
        val_a[2] = 64'h5;
        exp_a[2] = 64'h6;
        run_scenario("mismatch", -1);
        n_tests++;
        if (bus.mismatch_idx !== 2'd2 || bus.fail !== 1'b1 || bus.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch literal: got midx=%0d fail=%b pass=%b exp 2 1 0",
                     bus.mismatch_idx, bus.fail, bus.pass);
        end
        mask = 4'b1011;
        run_scenario("masked", -1);
        n_tests++;
        if (bus.pass !== 1'b1 || bus.fail !== 1'b0) begin
            n_fail++;
            $display("FAIL masked literal: got pass=%b fail=%b exp 1 0", bus.pass, bus.fail);
        end
    endtask

    task automatic test_timeout();
        pc_hold   = '0;
        trace_len = TRACE_MAX;
        for (int j = 0; j < TRACE_MAX; j++) pc_trace[j] = 64'(4 * j);
        set_default_vals();
        run_scenario("timeout", -1);
        n_tests++;
        if (bus.cycle_count !== 32'd15 || bus.timeout !== 1'b1 || bus.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout literal: got count=%0d timeout=%b pass=%b exp 15 1 0",
                     bus.cycle_count, bus.timeout, bus.pass);
        end
    endtask

    task automatic test_toggle_and_halt_wins();
        pc_hold   = '0;
        trace_len = TRACE_MAX;
        for (int j = 0; j < TRACE_MAX; j++) pc_trace[j] = (j % 2 == 0) ? 64'd8 : 64'd12;
        set_default_vals();
        run_scenario("toggle", -1);
        n_tests++;
        if (bus.timeout !== 1'b1 || bus.fail !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle literal: got timeout=%b fail=%b exp 1 1", bus.timeout, bus.fail);
        end
        // Stuck at 20 from run cycle 11: the fourth unchanged sample lands on
        // run cycle 15, the last one before timeout.
        for (int j = 11; j < TRACE_MAX; j++) pc_trace[j] = 64'd20;
        run_scenario("halt_wins", -1);
        n_tests++;
        if (bus.timeout !== 1'b0 || bus.pass !== 1'b1 || bus.cycle_count !== 32'd15) begin
            n_fail++;
            $display("FAIL halt_wins literal: got timeout=%b pass=%b count=%0d exp 0 1 15",
                     bus.timeout, bus.pass, bus.cycle_count);
        end
    endtask

    task automatic test_reset_in_check();
        setup_basic_trace();
        set_default_vals();
        // Halt at run cycle 7, so run cycle 9 is the second CHECK cycle.
        run_scenario("abort", 9);
        run_scenario("rerun", -1);
        n_tests++;
        if (bus.pass !== 1'b1 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL rerun literal: got pass=%b done=%b exp 1 1", bus.pass, bus.done);
        end
    endtask

    task automatic test_random();
        int pref;
        int nbad;
        int slot;
        for (int r = 0; r < 16; r++) begin
            pc_hold = 64'(4 * $urandom_range(0, 3));
            pref    = $urandom_range(0, 14);
            for (int j = 0; j < pref; j++) pc_trace[j] = 64'(4 * $urandom_range(0, 3));
            pc_trace[pref] = 64'(4 * $urandom_range(0, 7));
            trace_len = pref + 1;
            for (int i = 0; i < N_VALS; i++) begin
                val_a[i] = {$urandom(), $urandom()};
                exp_a[i] = val_a[i];
            end
            nbad = $urandom_range(0, 2);
            for (int b = 0; b < nbad; b++) begin
                slot = $urandom_range(0, N_VALS - 1);
                exp_a[slot] = exp_a[slot] ^ (64'd1 << $urandom_range(0, 63));
            end
            mask = N_VALS'($urandom_range(0, (1 << N_VALS) - 1));
            run_scenario($sformatf("random%0d", r), -1);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_timeout();
        test_toggle_and_halt_wins();
        test_reset_in_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
